// File: rtl/pipe_field.sv
// Scrolling pipe field: NUM_PIPES slots that scroll, spawn and retire once per frame,
// with bird collision detection and a saturating score counter.

module pipe_slot #(
  parameter int COORD_W     = 16,
  parameter int SPEED       = 5,
  parameter int OFFSCREEN_Y = -120,
  parameter int GAP_BASE    = 420
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_i,
  input  logic                      idle_i,
  input  logic                      run_i,
  input  logic                      spawn_i,
  input  logic [COORD_W-1:0]        sh_x_i,
  input  logic [COORD_W-1:0]        sh_y_i,
  input  logic                      sh_v_i,
  input  logic                      sh_sub_i,
  input  logic signed [COORD_W-1:0] bird_x_i,
  input  logic signed [COORD_W-1:0] bird_y_i,
  output logic [COORD_W-1:0]        x_o,
  output logic [COORD_W-1:0]        y_o,
  output logic                      v_o,
  output logic                      hit_o,
  output logic                      qual_o
);
  localparam logic signed [COORD_W:0]   DY_LO = (COORD_W+1)'(-96);
  localparam logic signed [COORD_W:0]   DY_HI = (COORD_W+1)'(55);
  localparam logic signed [COORD_W:0]   DX_LO = (COORD_W+1)'(80);
  localparam logic signed [COORD_W:0]   DX_HI = (COORD_W+1)'(220);
  localparam logic signed [COORD_W:0]   OFF_Y = (COORD_W+1)'(OFFSCREEN_Y);
  localparam logic signed [COORD_W:0]   SPD   = (COORD_W+1)'(SPEED);
  localparam logic signed [COORD_W+1:0] Q_OFF = (COORD_W+2)'(40);
  localparam logic signed [COORD_W+1:0] Q_MAX = (COORD_W+2)'(SPEED-1);
  localparam logic signed [COORD_W+1:0] Q_MIN = (COORD_W+2)'(0);

  logic [COORD_W-1:0]        x_q, y_q, x_d, y_d;
  logic                      v_q, v_d;
  logic [COORD_W-1:0]        src_x, src_y;
  logic                      src_v, src_sub;
  logic signed [COORD_W:0]   src_ext, upd_y, dx, dy;
  logic signed [COORD_W+1:0] sq;

  // Collision and scoring look at the pipe before this frame's move.
  assign dy = $signed({y_q[COORD_W-1], y_q}) - $signed({bird_y_i[COORD_W-1], bird_y_i});
  assign dx = $signed({x_q[COORD_W-1], x_q}) - $signed({bird_x_i[COORD_W-1], bird_x_i});
  assign sq = $signed({{2{y_q[COORD_W-1]}}, y_q}) - $signed({{2{bird_y_i[COORD_W-1]}}, bird_y_i}) + Q_OFF;

  assign hit_o  = v_q && (dy >= DY_LO) && (dy <= DY_HI) && ((dx > DX_HI) || (dx < DX_LO));
  assign qual_o = v_q && (sq >= Q_MIN) && (sq <= Q_MAX);

  always_comb begin
    src_x   = x_q;
    src_y   = y_q;
    src_v   = v_q;
    src_sub = v_q;
    if (spawn_i) begin
      src_x   = sh_x_i;
      src_y   = sh_y_i;
      src_v   = sh_v_i;
      src_sub = sh_sub_i;
    end
    src_ext = $signed({src_y[COORD_W-1], src_y});
    upd_y   = src_sub ? src_ext - SPD : src_ext;
    x_d     = src_x;
    y_d     = upd_y[COORD_W-1:0];
    v_d     = src_v && (upd_y >= OFF_Y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      v_q <= 1'b0;
    end else if (frame_i) begin
      if (idle_i) begin
        x_q <= COORD_W'(GAP_BASE);
        y_q <= COORD_W'(OFFSCREEN_Y);
        v_q <= 1'b0;
      end else if (run_i) begin
        x_q <= x_d;
        y_q <= y_d;
        v_q <= v_d;
      end
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign v_o = v_q;
endmodule

module pipe_field #(
  parameter int NUM_PIPES    = 3,
  parameter int COORD_W      = 16,
  parameter int SPEED        = 5,
  parameter int SPAWN_PERIOD = 64,
  parameter int SPAWN_Y      = 480,
  parameter int GAP_BASE     = 420,
  parameter int OFFSCREEN_Y  = -120,
  parameter int GROUND_X     = 104,
  parameter int SCORE_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_frame,
  input  logic [1:0]                     mode,
  input  logic [7:0]                     random,
  input  logic signed [COORD_W-1:0]      bird_x,
  input  logic signed [COORD_W-1:0]      bird_y,
  output logic [NUM_PIPES*COORD_W-1:0]   pipe_x,
  output logic [NUM_PIPES*COORD_W-1:0]   pipe_y,
  output logic [NUM_PIPES-1:0]           pipe_valid,
  output logic                           hit,
  output logic                           score_pulse,
  output logic [SCORE_W-1:0]             score
);
  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(SPAWN_PERIOD-1);
  localparam logic signed [COORD_W-1:0] GND_X    = COORD_W'(GROUND_X);

  logic [NUM_PIPES-1:0][COORD_W-1:0] x_s, y_s, sh_x, sh_y;
  logic [NUM_PIPES-1:0]              v_s, sh_v, sh_sub, hit_s, qual_s;
  logic [COORD_W-1:0]                new_x;
  logic [CNT_W-1:0]                  cnt_q;
  logic [SCORE_W-1:0]                score_q;
  logic                              hit_q, pulse_q;
  logic                              idle, run, spawn;

  assign idle  = (mode == 2'b00);
  assign run   = (mode == 2'b01);
  assign spawn = run && (cnt_q == '0);
  assign new_x = COORD_W'(GAP_BASE) + {{(COORD_W-8){1'b0}}, random};

  // Each slot shifts in from its upper neighbour; the top slot shifts in the fresh pipe unscrolled.
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
    if (i < NUM_PIPES-1) begin : g_mid
      assign sh_x[i]   = x_s[i+1];
      assign sh_y[i]   = y_s[i+1];
      assign sh_v[i]   = v_s[i+1];
      assign sh_sub[i] = v_s[i+1];
    end else begin : g_top
      assign sh_x[i]   = new_x;
      assign sh_y[i]   = COORD_W'(SPAWN_Y);
      assign sh_v[i]   = 1'b1;
      assign sh_sub[i] = 1'b0;
    end

    pipe_slot #(
      .COORD_W(COORD_W), .SPEED(SPEED), .OFFSCREEN_Y(OFFSCREEN_Y), .GAP_BASE(GAP_BASE)
    ) u_slot (
      .clk(clk), .rst(rst), .frame_i(new_frame), .idle_i(idle), .run_i(run), .spawn_i(spawn),
      .sh_x_i(sh_x[i]), .sh_y_i(sh_y[i]), .sh_v_i(sh_v[i]), .sh_sub_i(sh_sub[i]),
      .bird_x_i(bird_x), .bird_y_i(bird_y),
      .x_o(x_s[i]), .y_o(y_s[i]), .v_o(v_s[i]), .hit_o(hit_s[i]), .qual_o(qual_s[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (new_frame) begin
        if (idle) begin
          cnt_q   <= '0;
          score_q <= '0;
          hit_q   <= 1'b0;
        end else if (run) begin
          cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
          if ((|hit_s) || (bird_x <= GND_X))
            hit_q <= 1'b1;
          // Any number of qualifying pipes is worth one point; pulse fires even when saturated.
          if (!hit_q && (|qual_s)) begin
            score_q <= (&score_q) ? score_q : score_q + 1'b1;
            pulse_q <= 1'b1;
          end
        end
      end
    end
  end

  assign pipe_x      = x_s;
  assign pipe_y      = y_s;
  assign pipe_valid  = v_s;
  assign hit         = hit_q;
  assign score_pulse = pulse_q;
  assign score       = score_q;
endmodule

// File: tb/tb_pipe_field.sv
// Randomized bench for pipe_field against a slot-list reference model of the pipe field.

module tb_pipe_field;
  localparam int N = 3, W = 16;

  logic               clk = 1'b0, rst = 1'b1, new_frame = 1'b0;
  logic [1:0]         mode = 2'b00;
  logic [7:0]         random = 8'd0;
  logic signed [W-1:0] bird_x = '0, bird_y = '0;
  logic [N*W-1:0]     pipe_x, pipe_y;
  logic [N-1:0]       pipe_valid;
  logic               hit, score_pulse;
  logic [7:0]         score;

  pipe_field dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .mode(mode), .random(random),
    .bird_x(bird_x), .bird_y(bird_y), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .pipe_valid(pipe_valid), .hit(hit), .score_pulse(score_pulse), .score(score)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int mx[N], my[N], mv[N];
  int mcnt, mscore, mhit, mpulse;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int i); return int'($signed(pipe_x[i*W +: W])); endfunction
  function automatic int py(input int i); return int'($signed(pipe_y[i*W +: W])); endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mx[i] = 0; my[i] = 0; mv[i] = 0; end
    mcnt = 0; mscore = 0; mhit = 0; mpulse = 0;
  endtask

  // Pipe list: oldest first; a spawn drops the oldest and appends a new one at the top.
  task automatic model_step(input int md, input int rnd, input int bx, input int by);
    int coll, q, dx, dy, sp;
    mpulse = 0;
    if (md == 0) begin
      for (int i = 0; i < N; i++) begin mv[i] = 0; my[i] = -120; mx[i] = 420; end
      mcnt = 0; mscore = 0; mhit = 0;
    end else if (md == 1) begin
      coll = 0; q = 0;
      for (int i = 0; i < N; i++) if (mv[i] != 0) begin
        dy = my[i] - by; dx = mx[i] - bx;
        if (dy >= -96 && dy <= 55 && (dx > 220 || dx < 80)) coll = 1;
        if (dy + 40 >= 0 && dy + 40 <= 4) q = 1;
      end
      if (bx <= 104) coll = 1;
      if (q != 0 && mhit == 0) begin
        mpulse = 1;
        if (mscore < 255) mscore++;
      end
      if (coll != 0) mhit = 1;
      sp = (mcnt == 0);
      mcnt = (mcnt + 1) % 64;
      if (sp != 0)
        for (int i = 0; i < N-1; i++) begin mx[i] = mx[i+1]; my[i] = my[i+1]; mv[i] = mv[i+1]; end
      for (int i = 0; i < N; i++) begin
        if (!(sp != 0 && i == N-1) && mv[i] != 0) begin
          my[i] -= 5;
          if (my[i] < -120) mv[i] = 0;
        end
      end
      if (sp != 0) begin mx[N-1] = 420 + rnd; my[N-1] = 480; mv[N-1] = 1; end
    end
  endtask

  task automatic check_all(input string tag, input bit full);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.v%0d", tag, i), {31'b0, pipe_valid[i]}, mv[i]);
      if (full || mv[i] != 0) begin
        chk($sformatf("%s.x%0d", tag, i), px(i), mx[i]);
        chk($sformatf("%s.y%0d", tag, i), py(i), my[i]);
      end
    end
    chk({tag, ".score"}, {24'b0, score}, mscore);
    chk({tag, ".hit"}, {31'b0, hit}, mhit);
    chk({tag, ".pulse"}, {31'b0, score_pulse}, mpulse);
  endtask

  // One strobed frame, then a gap cycle with garbage on mode/random that must be ignored.
  task automatic frame(input int md, input int rnd, input int bx, input int by);
    @(negedge clk);
    mode = md[1:0]; random = rnd[7:0]; bird_x = W'(bx); bird_y = W'(by); new_frame = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    model_step(md, rnd, bx, by);
    check_all("frm", md == 0);
    mode = 2'($urandom); random = 8'($urandom);
    @(negedge clk);
    chk("pulse_clr", {31'b0, score_pulse}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    #1 model_reset(); check_all("rst", 1'b1);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int r, by, k;
    model_reset();
    #1 check_all("por", 1'b1);
    @(negedge clk); rst = 1'b0;

    // First RUN frame spawns into the top slot.
    frame(1, 10, 600, 0);
    chk("spawn1.v2", {31'b0, pipe_valid[2]}, 1);
    chk("spawn1.x2", px(2), 430);
    chk("spawn1.y2", py(2), 480);
    chk("spawn1.v10", {30'b0, pipe_valid[1:0]}, 0);
    for (int i = 0; i < 64; i++) frame(1, 0, 600, 0);
    chk("spawn2.y1", py(1), 160);
    chk("spawn2.y2", py(2), 480);

    // Collision geometry: gap edge, inside gap, then outside gap.
    do_reset();
    frame(1, 80, 600, 0);
    for (int i = 0; i < 48; i++) frame(1, 0, 600, 0);
    chk("col.y2", py(2), 240);
    frame(1, 0, 420, 200); chk("col.dx80", {31'b0, hit}, 0);
    frame(1, 0, 300, 195); chk("col.dx200", {31'b0, hit}, 0);
    frame(1, 0, 250, 190); chk("col.dx250", {31'b0, hit}, 1);
    for (int i = 0; i < 10; i++) frame(2 + (i & 1), 0, 600, 0);
    chk("col.sticky", {31'b0, hit}, 1);
    frame(1, 0, 600, 0);
    frame(0, 0, 600, 0);
    chk("idle.hit", {31'b0, hit}, 0);
    chk("idle.valid", {29'b0, pipe_valid}, 0);

    // Scoring, then saturation while tracking the newest pipe.
    do_reset();
    frame(1, 0, 600, 0);
    frame(1, 0, 270, 517);
    chk("score1", {24'b0, score}, 1);
    frame(1, 0, 600, 0);
    for (int i = 0; i < 260; i++) frame(1, 0, 270, my[N-1] + 37);
    chk("score_sat", {24'b0, score}, 255);

    // Randomized run/freeze/idle mix with birds placed near pipes.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      k = $urandom_range(0, N-1);
      by = ($urandom_range(0, 1) != 0) ? my[k] + $urandom_range(0, 150) - 100 : $urandom_range(0, 500);
      frame((r == 0) ? 0 : (r < 3) ? 2 + (r & 1) : 1, $urandom_range(0, 255),
            $urandom_range(80, 700), by);
    end

    // Asynchronous reset right after a scoring edge, with pipes live and score 7.
    do_reset();
    for (int i = 0; i < 65; i++) frame(1, 0, 600, 0);
    for (int i = 0; i < 6; i++) frame(1, 0, 270, my[N-1] + 37);
    @(negedge clk);
    mode = 2'b01; bird_x = W'(270); bird_y = W'(my[N-1] + 37); new_frame = 1'b1;
    @(posedge clk); #1 new_frame = 1'b0;
    chk("pre_rst.score", {24'b0, score}, 7);
    chk("pre_rst.pulse", {31'b0, score_pulse}, 1);
    chk("pre_rst.valid", {29'b0, pipe_valid}, 3'b110);
    #1 rst = 1'b1;
    #1 model_reset(); check_all("mid_rst", 1'b1);
    @(negedge clk); rst = 1'b0;
    frame(1, 10, 600, 0);
    chk("post_rst.v2", {31'b0, pipe_valid[2]}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_field.md
PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 SHALL have parameter NUM_PIPES, default 3, number of pipe slots (2..8).
REQ-002 SHALL have parameter COORD_W, default 16, signed coordinate width.
REQ-003 SHALL have parameter SPEED, default 5, scroll step in pixels per frame.
REQ-004 SHALL have parameter SPAWN_PERIOD, default 64, frames between spawns.
REQ-005 SHALL have parameters SPAWN_Y (480), GAP_BASE (420), OFFSCREEN_Y (-120), GROUND_X (104), scoring and collision geometry.
REQ-006 SHALL have parameter SCORE_W, default 8, score counter width.
REQ-007 SHALL have port clk, input, 1, sole clock; one clock, all state on rising edge.
REQ-008 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port new_frame, input, 1, one-cycle frame strobe.
REQ-010 SHALL have port mode, input, 2, 00 IDLE, 01 RUN, 10 FREEZE, 11 treated as FREEZE.
REQ-011 SHALL have port random, input, 8, unsigned gap offset from the shared random source.
REQ-012 SHALL have ports bird_x and bird_y, input, COORD_W signed each, bird position.
REQ-013 SHALL have ports pipe_x and pipe_y, output, NUM_PIPES*COORD_W each, packed signed positions, slot 0 in LSBs.
REQ-014 SHALL have port pipe_valid, output, NUM_PIPES, slot occupied.
REQ-015 SHALL have ports hit (output, 1, sticky collision flag), score_pulse (output, 1, one-cycle point strobe) and score (output, SCORE_W, points).

Function
REQ-016 SHALL update state only on clock edges where new_frame=1, with outputs valid the following cycle; mode is sampled only at those edges.
REQ-017 IDLE frame SHALL set all pipe_valid=0, all pipe_y=OFFSCREEN_Y, all pipe_x=GAP_BASE, spawn counter=0, score=0, hit=0.
REQ-018 FREEZE frame SHALL hold all state; score_pulse=0.
REQ-019 RUN frame SHALL subtract SPEED from every valid pipe_y; invalid slots hold.
REQ-020 RUN frame SHALL increment spawn counter modulo SPAWN_PERIOD; a spawn occurs when the pre-increment value is 0.
REQ-021 On spawn, slot i SHALL take slot i+1 (its y minus SPEED, x and valid unchanged) for i<NUM_PIPES-1, slot 0 is discarded, and last slot SHALL load x=GAP_BASE+random (zero-extended), y=SPAWN_Y, valid=1.
REQ-022 A valid pipe whose updated y is below OFFSCREEN_Y SHALL become invalid in the same frame.
REQ-023 Collision for a valid pipe, evaluated on pre-update values: dy=pipe_y-bird_y within [-96,55] inclusive AND dx=pipe_x-bird_x >220 or <80.
REQ-024 RUN frame SHALL set hit=1 if any pipe collides or bird_x<=GROUND_X; hit remains 1 until IDLE or reset.
REQ-025 Once hit=1, RUN frames SHALL still scroll pipes but SHALL NOT score.
REQ-026 Score qualifies for a valid pipe when pipe_y-bird_y+40 lies in [0,SPEED-1] on pre-update values.
REQ-027 If any pipe qualifies and hit=0, score SHALL increment by exactly 1 (multiple qualifying pipes count once) and score_pulse SHALL be 1 for exactly one cycle.
REQ-028 Score SHALL saturate at 2^SCORE_W-1; score_pulse still fires at saturation.
REQ-029 Arithmetic SHALL be signed COORD_W; differences are computed at COORD_W+1 bits so no overflow affects comparisons.
REQ-030 score_pulse SHALL be 0 on every cycle without a scoring frame.

Reset
REQ-031 Asserting rst at any time, including mid-frame, SHALL immediately clear pipe_valid, pipe_x, pipe_y, spawn counter, score, hit and score_pulse to 0.
REQ-032 After rst deassertion, the first RUN frame SHALL spawn (counter=0).

Verification
REQ-033 Reset, then 1 RUN frame with random=10 -> slot 2 valid, x=430, y=480; other slots invalid; score=0.
REQ-034 65 RUN frames, random=0, bird far away (bird_x=600, bird_y=0) -> second spawn on frame 65; slot 1 y=480-64*5=160; slot 2 y=480.
REQ-035 Pipe y=240, x=500, bird_x=420, bird_y=200 (dy=40, dx=80, inside gap) -> no hit; bird_x=300 (dx=200) no hit; bird_x=250 (dx=250) -> hit=1 next cycle, sticky through FREEZE.
REQ-036 Pipe reaches y with pipe_y-bird_y+40=3 -> score 0->1, score_pulse high one cycle; next frame no pulse; score=255 stays 255 with pulse.
REQ-037 FREEZE for 10 frames then RUN -> positions and counter unchanged across FREEZE; IDLE frame -> all cleared per REQ-017.
REQ-038 Assert rst between strobes with 3 valid pipes and score=7 -> all outputs 0 in same cycle, no pulse.
